// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and frame width
// Purpose: common types for the SPI master and slave on the shared 4-wire bus.
// Ports: none (package).
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

   localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SPI half-period timebase
// Purpose: counts system clocks per sck half-period while a frame is active and
//          decodes the sck edge that the next half-period boundary produces.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_en         count enable (frame active); counter held at 0 otherwise
//   i_sck        current sck level, used to classify the boundary
//   o_half_tick  last cycle of a half-period
//   o_sck_rise   boundary will drive sck high
//   o_sck_fall   boundary will drive sck low
module spi_sck_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_sck,
   output logic o_half_tick,
   output logic o_sck_rise,
   output logic o_sck_fall
);

   // One bit is kept even for CLK_DIV=1 so the counter never has zero width.
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_tick;

   assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_en || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_half_tick = w_tick;
   assign o_sck_rise  = w_tick && !i_sck;
   assign o_sck_fall  = w_tick &&  i_sck;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first)
// Purpose: runs one DATA_WIDTH-bit frame per accepted start request, generating
//          sck from the system clock and returning the received word.
// Config macro: SPI_MASTER_LOOPBACK_EN - rx samples master_mosi instead of master_miso.
// Ports:
//   clk                system clock
//   master_reset       asynchronous active-high reset; aborts a frame
//   master_start       frame request, honoured only in IDLE
//   master_data_trans  word to send, latched on acceptance
//   master_miso        serial data from the slave
//   master_sck         SPI clock, idles low
//   master_ss          slave select, active low
//   master_mosi        serial data to the slave
//   master_data_rec    last received word, updated in the done cycle
//   master_busy        high from SETUP through HOLD
//   master_done        one-cycle end-of-frame pulse
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_W,
   parameter int CLK_DIV    = 2
)(
   input  logic                  clk,
   input  logic                  master_reset,
   input  logic                  master_start,
   input  logic [DATA_WIDTH-1:0] master_data_trans,
   input  logic                  master_miso,
   output logic                  master_sck,
   output logic                  master_ss,
   output logic                  master_mosi,
   output logic [DATA_WIDTH-1:0] master_data_rec,
   output logic                  master_busy,
   output logic                  master_done
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   spi_state_t            r_state;
   logic                  r_sck;
   logic                  r_ss;
   logic                  r_busy;
   logic                  r_done;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [DATA_WIDTH-1:0] r_data_rec;

   logic w_half_tick;
   logic w_sck_rise;
   logic w_sck_fall;
   logic w_rx_in;
   logic w_last_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign w_rx_in = master_mosi;
`else
   assign w_rx_in = master_miso;
`endif

   assign w_last_bit = (r_bit_cnt == BW'(DATA_WIDTH - 1));

   // The timebase runs only while busy so every frame starts from a fresh count.
   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .i_clk       (clk),
      .i_rst       (master_reset),
      .i_en        (r_busy),
      .i_sck       (r_sck),
      .o_half_tick (w_half_tick),
      .o_sck_rise  (w_sck_rise),
      .o_sck_fall  (w_sck_fall)
   );

   always_ff @(posedge clk or posedge master_reset) begin
      if (master_reset) begin
         r_state    <= IDLE;
         r_sck      <= 1'b0;
         r_ss       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bit_cnt  <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_data_rec <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (master_start) begin
                  r_state   <= SETUP;
                  r_ss      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
                  r_tx      <= master_data_trans;
                  r_rx      <= '0;
               end
            end
            SETUP: begin
               if (w_half_tick) begin
                  r_state <= XFER;
               end
            end
            XFER: begin
               // First half-period of XFER is low, so rises land on odd boundaries
               // and the frame ends on the final falling boundary.
               if (w_sck_rise) begin
                  r_sck <= 1'b1;
                  r_rx  <= {r_rx[DATA_WIDTH-2:0], w_rx_in};
               end else if (w_sck_fall) begin
                  r_sck <= 1'b0;
                  if (w_last_bit) begin
                     // mosi keeps bit 0 through HOLD
                     r_state <= HOLD;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_tx      <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
            HOLD: begin
               if (w_half_tick) begin
                  r_state    <= DONE;
                  r_ss       <= 1'b1;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_data_rec <= r_rx;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign master_sck      = r_sck;
   assign master_ss       = r_ss;
   assign master_mosi     = r_tx[DATA_WIDTH-1];
   assign master_data_rec = r_data_rec;
   assign master_busy     = r_busy;
   assign master_done     = r_done;

endmodule
